// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_pattern_gen
//  Description : Raster timing generator and test-pattern source. It drives
//                rgb/hsync/vsync/de/frame_start for the defog pipeline and
//                offers colour bars, gray ramp, checkerboard and a moving
//                diagonal.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CHK_LOG2 = 5
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] o_rgb,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] c_h_last     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_h_act      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_hs_start   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_hs_end     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] c_v_last     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_v_act      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] c_vs_start   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_vs_end     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] c_bar_last   = BW'(BAR_W - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [7:0]    r_frame_cnt;
    logic [1:0]    r_pattern;
    logic [BW-1:0] r_bar_px;
    logic [2:0]    r_bar_idx;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_origin;
    logic [1:0]    w_pattern;
    logic          w_de;
    logic          w_hs;
    logic          w_vs;
    logic          w_chk;
    logic [7:0]    w_x8;
    logic [7:0]    w_diag;
    logic [23:0]   w_pix;

    assign w_h_wrap  = (r_h_cnt == c_h_last);
    assign w_v_wrap  = (r_v_cnt == c_v_last);
    assign w_origin  = (r_h_cnt == '0) && (r_v_cnt == '0);
    // The first pixel of a frame already uses the pattern being sampled now.
    assign w_pattern = w_origin ? pattern_sel : r_pattern;
    assign w_de      = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs      = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_vs      = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    assign w_chk     = r_h_cnt[CHK_LOG2] ^ r_v_cnt[CHK_LOG2];
    assign w_x8      = 8'(r_h_cnt);
    assign w_diag    = w_x8 + 8'(r_v_cnt) + r_frame_cnt;

    // Pixel colour for the current raster position.
    always_comb begin
        w_pix = '0;
        case (w_pattern)
            2'b00:   w_pix = {{8{~r_bar_idx[1]}}, {8{~r_bar_idx[2]}}, {8{~r_bar_idx[0]}}};
            2'b01:   w_pix = {3{w_x8}};
            2'b10:   w_pix = w_chk ? 24'hFF_FFFF : 24'h00_0000;
            default: w_pix = {3{w_diag}};
        endcase
    end

    // Raster counters, frame counter, per-line bar sub-counter, pattern latch.
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
            r_pattern   <= '0;
            r_bar_px    <= '0;
            r_bar_idx   <= '0;
        end else if (!en) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
            r_bar_px    <= '0;
            r_bar_idx   <= '0;
        end else begin
            if (w_origin) begin
                r_pattern <= pattern_sel;
            end
            if (w_h_wrap) begin
                r_h_cnt   <= '0;
                r_bar_px  <= '0;
                r_bar_idx <= '0;
                if (w_v_wrap) begin
                    r_v_cnt     <= '0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else begin
                    r_v_cnt <= r_v_cnt + VW'(1);
                end
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
                if (r_bar_px == c_bar_last) begin
                    r_bar_px  <= '0;
                    r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_px  <= r_bar_px + BW'(1);
                end
            end
        end
    end

    // Registered video outputs; idle levels while in reset or disabled.
    always_ff @(posedge pixelclk) begin
        if (!reset_n || !en) begin
            o_rgb         <= '0;
            o_de          <= 1'b0;
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_frame_start <= 1'b0;
        end else begin
            o_rgb         <= w_de ? w_pix : 24'h00_0000;
            o_de          <= w_de;
            o_hsync       <= w_hs ? HS_POL : ~HS_POL;
            o_vsync       <= w_vs ? VS_POL : ~VS_POL;
            o_frame_start <= w_origin;
        end
    end

endmodule
`default_nettype wire
